// File: rtl/prog_load_run_ctrl.sv
// Load/clear/run sequencer: streams IM then DM into the datapath, runs until halt.
// Optional RUN_TIMEOUT_EN adds a run-cycle watchdog and a sticky timeout output.
module prog_load_run_ctrl #(
    parameter int IM_DEPTH   = 256,
    parameter int DM_DEPTH   = 256,
    parameter int CLR_CYCLES = 2
`ifdef RUN_TIMEOUT_EN
    ,
    parameter logic [15:0] MAX_RUN_CYCLES = 16'hFFFF
`endif
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        start,
    input  logic        s_valid,
    input  logic [15:0] s_data,
    input  logic        s_last,
    output logic        s_ready,
    input  logic        hlt_req,
    output logic        test_normal,
    output logic        ext_instr_we,
    output logic [15:0] ext_instr_addr,
    output logic [15:0] ext_instr_data,
    output logic        ext_data_write_en,
    output logic [15:0] ext_data_addr,
    output logic [15:0] ext_data_data,
    output logic        core_clr,
    output logic        clk_en,
    output logic        busy,
    output logic        done,
    output logic        load_err,
    output logic [15:0] run_cycles
`ifdef RUN_TIMEOUT_EN
    ,
    output logic        timeout
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_IM, S_LOAD_DM, S_CLEAR, S_RUN, S_HALTED
    } state_t;

    localparam logic [16:0] IM_D  = 17'(IM_DEPTH);
    localparam logic [16:0] DM_D  = 17'(DM_DEPTH);
    localparam logic [16:0] CLR_L = 17'(CLR_CYCLES - 1);

    state_t      state, nxt;
    logic [16:0] cnt;
    logic        hs, wr_im, wr_dm, ovf, cnt_inc, cnt_clr, clr_all;
`ifdef RUN_TIMEOUT_EN
    logic        tmo_set;
`endif

    assign hs = s_valid & s_ready;

    always_comb begin
        nxt     = state;
        wr_im   = 1'b0;
        wr_dm   = 1'b0;
        ovf     = 1'b0;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        clr_all = 1'b0;
`ifdef RUN_TIMEOUT_EN
        tmo_set = 1'b0;
`endif
        unique case (state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    nxt     = S_LOAD_IM;
                    clr_all = 1'b1;
                end
            end
            S_LOAD_IM: begin
                if (hs) begin
                    wr_im   = (cnt < IM_D);
                    ovf     = !wr_im;
                    cnt_inc = wr_im;
                    if (s_last) begin
                        nxt     = S_LOAD_DM;
                        cnt_clr = 1'b1;
                    end
                end
            end
            S_LOAD_DM: begin
                if (hs) begin
                    wr_dm   = (cnt < DM_D);
                    ovf     = !wr_dm;
                    cnt_inc = wr_dm;
                    if (s_last) begin
                        nxt     = S_CLEAR;
                        cnt_clr = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                cnt_inc = 1'b1;
                if (cnt == CLR_L) begin
                    nxt     = S_RUN;
                    cnt_clr = 1'b1;
                end
            end
            S_RUN: begin
                if (hlt_req) nxt = S_HALTED;
`ifdef RUN_TIMEOUT_EN
                else if (run_cycles == MAX_RUN_CYCLES - 16'd1) begin
                    nxt     = S_HALTED;
                    tmo_set = 1'b1;
                end
`endif
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            if (clr_all || cnt_clr) cnt <= '0;
            else if (cnt_inc)       cnt <= cnt + 17'd1;
        end
    end

    // Every output is registered from the next state so it aligns with it.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            s_ready           <= 1'b0;
            test_normal       <= 1'b1;
            core_clr          <= 1'b1;
            clk_en            <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            load_err          <= 1'b0;
            run_cycles        <= '0;
            ext_instr_we      <= 1'b0;
            ext_instr_addr    <= '0;
            ext_instr_data    <= '0;
            ext_data_write_en <= 1'b0;
            ext_data_addr     <= '0;
            ext_data_data     <= '0;
`ifdef RUN_TIMEOUT_EN
            timeout           <= 1'b0;
`endif
        end else begin
            s_ready     <= (nxt == S_LOAD_IM) || (nxt == S_LOAD_DM);
            test_normal <= !((nxt == S_CLEAR) || (nxt == S_RUN));
            core_clr    <= !((nxt == S_RUN) || (nxt == S_HALTED));
            clk_en      <= (nxt == S_LOAD_IM) || (nxt == S_LOAD_DM) ||
                           (nxt == S_CLEAR) || (nxt == S_RUN);
            busy        <= !((nxt == S_IDLE) || (nxt == S_HALTED));

            ext_instr_we      <= wr_im;
            ext_data_write_en <= wr_dm;
            if (wr_im) begin
                ext_instr_addr <= cnt[15:0];
                ext_instr_data <= s_data;
            end
            if (wr_dm) begin
                ext_data_addr <= cnt[15:0];
                ext_data_data <= s_data;
            end

            if (clr_all)              done <= 1'b0;
            else if (nxt == S_HALTED) done <= 1'b1;

            if (clr_all)  load_err <= 1'b0;
            else if (ovf) load_err <= 1'b1;

            if (clr_all) run_cycles <= '0;
            else if (state == S_RUN && run_cycles != 16'hFFFF)
                run_cycles <= run_cycles + 16'd1;
`ifdef RUN_TIMEOUT_EN
            if (clr_all)      timeout <= 1'b0;
            else if (tmo_set) timeout <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_prog_load_run_ctrl.sv
// Randomized bench for prog_load_run_ctrl against a write-list reference model.
// Builds with or without RUN_TIMEOUT_EN.
module tb_prog_load_run_ctrl;

    localparam int IMD  = 4;
    localparam int DMD  = 6;
    localparam int CLR  = 2;
    localparam int MAXR = 20;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        hlt_req = 1'b0;
    logic        s_ready, test_normal, ext_instr_we, ext_data_write_en;
    logic [15:0] ext_instr_addr, ext_instr_data, ext_data_addr, ext_data_data;
    logic        core_clr, clk_en, busy, done, load_err;
    logic [15:0] run_cycles;
`ifdef RUN_TIMEOUT_EN
    logic        timeout;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] im_w[$];
    logic [15:0] dm_w[$];
    logic [31:0] act_im[$];
    logic [31:0] act_dm[$];

    always #5 clk = ~clk;

    prog_load_run_ctrl #(
        .IM_DEPTH(IMD), .DM_DEPTH(DMD), .CLR_CYCLES(CLR)
`ifdef RUN_TIMEOUT_EN
        , .MAX_RUN_CYCLES(16'(MAXR))
`endif
    ) dut (
        .clk(clk), .clr_n(clr_n), .start(start),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .hlt_req(hlt_req),
        .test_normal(test_normal),
        .ext_instr_we(ext_instr_we),
        .ext_instr_addr(ext_instr_addr),
        .ext_instr_data(ext_instr_data),
        .ext_data_write_en(ext_data_write_en),
        .ext_data_addr(ext_data_addr),
        .ext_data_data(ext_data_data),
        .core_clr(core_clr), .clk_en(clk_en), .busy(busy),
        .done(done), .load_err(load_err), .run_cycles(run_cycles)
`ifdef RUN_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    // Memories write on the falling edge; record what they would see.
    always @(negedge clk) begin
        if (ext_instr_we)
            act_im.push_back({ext_instr_addr, ext_instr_data});
        if (ext_data_write_en)
            act_dm.push_back({ext_data_addr, ext_data_data});
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_ready"}, s_ready, 1'b0);
        chk({pfx, "_tn"}, test_normal, 1'b1);
        chk({pfx, "_clr"}, core_clr, 1'b1);
        chk({pfx, "_clken"}, clk_en, 1'b0);
        chk({pfx, "_busy"}, busy, 1'b0);
        chk({pfx, "_done"}, done, 1'b0);
        chk({pfx, "_err"}, load_err, 1'b0);
        chk({pfx, "_rc"}, run_cycles, 16'd0);
        chk({pfx, "_we"}, {ext_instr_we, ext_data_write_en}, 2'b00);
        chk({pfx, "_iad"}, {ext_instr_addr, ext_instr_data}, 32'd0);
        chk({pfx, "_dad"}, {ext_data_addr, ext_data_data}, 32'd0);
`ifdef RUN_TIMEOUT_EN
        chk({pfx, "_tmo"}, timeout, 1'b0);
`endif
    endtask

    task automatic send(input logic [15:0] d, input logic last,
                        input int gmin, input int gmax);
        int g, k;
        g = int'($urandom_range(gmax, gmin));
        s_valid = 1'b0;
        repeat (g) begin
            start   = ($urandom % 4 == 0);
            hlt_req = $urandom % 2;
            tick;
        end
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        k = 0;
        while (!s_ready && k < 50) begin
            tick;
            k++;
        end
        if (!s_ready) chk("ready_wait", s_ready, 1'b1);
        tick;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic session(input int h, input int gmin, input int gmax);
        int ni, nd, k, ei, ed, exp_rc;
`ifdef RUN_TIMEOUT_EN
        logic exp_to;
`endif
        ni = im_w.size();
        nd = dm_w.size();
        ei = (ni < IMD) ? ni : IMD;
        ed = (nd < DMD) ? nd : DMD;
        act_im.delete();
        act_dm.delete();

        start = 1'b1;
        tick;
        start = 1'b0;
        chk("ld_ready", s_ready, 1'b1);
        chk("ld_state", {busy, test_normal, core_clr, clk_en}, 4'b1111);
        chk("ld_sticky", {done, load_err}, 2'b00);
        chk("ld_rc", run_cycles, 16'd0);

        foreach (im_w[i]) send(im_w[i], i == ni - 1, gmin, gmax);
        foreach (dm_w[i]) send(dm_w[i], i == nd - 1, gmin, gmax);
        hlt_req = 1'b0;

        chk("load_err", load_err, (ni > IMD) || (nd > DMD));
        chk("clr_entry", {s_ready, test_normal, core_clr, clk_en}, 4'b0011);
        k = 0;
        while (core_clr && k < 20) begin
            tick;
            k++;
        end
        chk("clr_len", k, CLR);
        chk("run_entry", {test_normal, clk_en, busy}, 3'b011);
        chk("run_rc0", run_cycles, 16'd0);

        chk("im_count", act_im.size(), ei);
        for (int i = 0; i < ei && i < act_im.size(); i++)
            chk("im_write", act_im[i], {i[15:0], im_w[i]});
        chk("dm_count", act_dm.size(), ed);
        for (int i = 0; i < ed && i < act_dm.size(); i++)
            chk("dm_write", act_dm[i], {i[15:0], dm_w[i]});

`ifdef RUN_TIMEOUT_EN
        exp_to = (h > MAXR - 1);
        exp_rc = exp_to ? MAXR : h + 1;
`else
        exp_rc = h + 1;
`endif
        k = 0;
        while (busy && run_cycles != h[15:0] && k < 200) begin
            tick;
            k++;
        end
        if (busy) begin
            hlt_req = 1'b1;
            tick;
            hlt_req = 1'b0;
        end
        chk("halt_state", {busy, done, clk_en, core_clr, test_normal, s_ready},
            6'b010010);
        chk("halt_rc", run_cycles, exp_rc);
`ifdef RUN_TIMEOUT_EN
        chk("timeout", timeout, exp_to);
`endif
        hlt_req = 1'b1;
        repeat (3) tick;
        hlt_req = 1'b0;
        chk("rc_frozen", run_cycles, exp_rc);
        chk("done_sticky", {done, busy}, 2'b10);
    endtask

    task automatic fill_rand(input int ni, input int nd);
        im_w.delete();
        dm_w.delete();
        repeat (ni) im_w.push_back(16'($urandom));
        repeat (nd) dm_w.push_back(16'($urandom));
    endtask

    initial begin
        repeat (2) tick;
        chk_reset_vals("rst");
        clr_n = 1'b1;
        tick;

        // Abandon a load partway through with an asynchronous reset.
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 3; i++) send(16'(16'hB000 + i), 1'b0, 0, 1);
        #2 clr_n = 1'b0;
        #1 chk_reset_vals("rst_mid");
        tick;
        clr_n = 1'b1;
        tick;

        im_w = '{16'hA001, 16'hA002, 16'hA003};
        dm_w = '{16'h0055};
        session(10, 0, 0);

        // IM overflow plus a DM stream with valid toggling every other cycle.
        fill_rand(6, 6);
        session(int'($urandom_range(15, 0)), 1, 1);

`ifdef RUN_TIMEOUT_EN
        fill_rand(2, 2);
        session(MAXR + 5, 0, 1);
        fill_rand(3, 1);
        session(MAXR - 1, 0, 1);
`endif

        repeat (20) begin
            fill_rand(int'($urandom_range(6, 1)), int'($urandom_range(8, 1)));
            session(int'($urandom_range(25, 0)), 0, 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
